// File: rtl/ifft_bitreverse.sv
// ---------------------------------------------------------------------------
// ifft_bitreverse
//   Output reorder buffer for the IFFT datapath. The butterfly chain delivers
//   each 2^LGSIZE-sample frame in bit-reversed index order; this block
//   double-buffers the frame and replays the previous frame in natural order,
//   with o_sync marking natural-order sample 0. No arithmetic on samples.
//
// Ports
//   i_clk       clock, rising edge
//   i_areset_n  asynchronous active-low reset
//   i_ce        sample strobe, one sample per strobe
//   i_sync      marks sample 0 of an input frame (only honoured before lock)
//   i_data      {real, imag} input sample, real in the upper WIDTH bits
//   o_data      reordered sample, same packing as i_data
//   o_sync      high with natural-order sample 0 of each output frame
// ---------------------------------------------------------------------------
module ifft_bitreverse #(
    parameter int LGSIZE = 9,
    parameter int WIDTH  = 22
) (
    input  logic               i_clk,
    input  logic               i_areset_n,
    input  logic               i_ce,
    input  logic               i_sync,
    input  logic [2*WIDTH-1:0] i_data,
    output logic [2*WIDTH-1:0] o_data,
    output logic               o_sync
);

    localparam int N = 2 ** LGSIZE;
    localparam logic [LGSIZE:0] ADDR_ZERO = (LGSIZE + 1)'(0);
    localparam logic [LGSIZE:0] ADDR_ONE  = (LGSIZE + 1)'(1);
    localparam logic [LGSIZE:0] LAST_FILL = (LGSIZE + 1)'(N - 1);
    localparam logic [LGSIZE-1:0] K_ZERO  = LGSIZE'(0);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'b00,
        FILL      = 2'b01,
        RUN       = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [LGSIZE:0]     r_wraddr;
    logic [LGSIZE:0]     w_wraddr_next;
    logic                w_we;
    logic [LGSIZE:0]     w_rdaddr;
    logic [2*WIDTH-1:0]  w_rddata;

    // Two banks of N words; the bank is the MSB of the address. No reset.
    logic [2*WIDTH-1:0]  r_mem [0:2*N-1];

    // Reverse the order of the LGSIZE index bits.
    function automatic logic [LGSIZE-1:0] bitrev(input logic [LGSIZE-1:0] k);
        logic [LGSIZE-1:0] r;
        r = K_ZERO;
        for (int b = 0; b < LGSIZE; b++) begin
            r[b] = k[LGSIZE-1-b];
        end
        return r;
    endfunction

    // Read always targets the bank opposite the one being written, so the
    // frame being replayed is never overwritten while it is read.
    assign w_rdaddr = {~r_wraddr[LGSIZE], bitrev(r_wraddr[LGSIZE-1:0])};
    assign w_rddata = r_mem[w_rdaddr];

    // Next-state, write-address and write-enable logic.
    always_comb begin
        w_state_next  = r_state;
        w_wraddr_next = r_wraddr;
        w_we          = 1'b0;
        case (r_state)
            WAIT_SYNC: begin
                // Samples before the first sync are dropped; the sync sample
                // itself lands at index 0 of bank 0.
                if (i_ce && i_sync) begin
                    w_we          = 1'b1;
                    w_wraddr_next = ADDR_ONE;
                    w_state_next  = FILL;
                end else begin
                    w_wraddr_next = ADDR_ZERO;
                end
            end
            FILL: begin
                if (i_ce) begin
                    w_we          = 1'b1;
                    w_wraddr_next = r_wraddr + ADDR_ONE;
                    if (r_wraddr == LAST_FILL) begin
                        w_state_next = RUN;
                    end else begin
                        w_state_next = FILL;
                    end
                end else begin
                    w_state_next = FILL;
                end
            end
            RUN: begin
                // Frame boundaries come only from the address wrap; i_sync
                // is ignored from here until reset.
                if (i_ce) begin
                    w_we          = 1'b1;
                    w_wraddr_next = r_wraddr + ADDR_ONE;
                end else begin
                    w_wraddr_next = r_wraddr;
                end
            end
            default: begin
                w_state_next  = WAIT_SYNC;
                w_wraddr_next = ADDR_ZERO;
            end
        endcase
    end

    // State and write-address registers.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state  <= WAIT_SYNC;
            r_wraddr <= ADDR_ZERO;
        end else begin
            r_state  <= w_state_next;
            r_wraddr <= w_wraddr_next;
        end
    end

    // Sample RAM write port.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[r_wraddr] <= i_data;
        end
    end

    // Registered outputs; zero outside RUN so unwritten RAM never escapes.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_data <= {(2*WIDTH){1'b0}};
            o_sync <= 1'b0;
        end else if (i_ce) begin
            if (r_state == RUN) begin
                o_data <= w_rddata;
                o_sync <= (r_wraddr[LGSIZE-1:0] == K_ZERO);
            end else begin
                o_data <= {(2*WIDTH){1'b0}};
                o_sync <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifft_bitreverse.sv
module tb_ifft_bitreverse;

    localparam int LG = 3;
    localparam int W  = 8;
    localparam int N  = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce    = 1'b0;
    logic          sync  = 1'b0;
    logic [2*W-1:0] din  = '0;
    logic [2*W-1:0] dout;
    logic          osync;

    ifft_bitreverse #(.LGSIZE(LG), .WIDTH(W)) dut (
        .i_clk      (clk),
        .i_areset_n (rst_n),
        .i_ce       (ce),
        .i_sync     (sync),
        .i_data     (din),
        .o_data     (dout),
        .o_sync     (osync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: every accepted sample since lock, indexed by arrival.
    int             locked = 0;
    int             cnt    = 0;
    logic [2*W-1:0] hist[$];
    logic [2*W-1:0] exp_d  = '0;
    logic           exp_s  = 1'b0;

    function automatic int brev(input int n);
        int r;
        r = 0;
        for (int b = 0; b < LG; b++) r = r * 2 + ((n >> b) & 1);
        return r;
    endfunction

    task automatic model_reset();
        locked = 0;
        cnt    = 0;
        hist.delete();
        exp_d  = '0;
        exp_s  = 1'b0;
    endtask

    // Output n of frame f is input bitrev(n) of frame f-1, produced on the
    // strobe that accepts input n of frame f.
    task automatic model(input logic s, input logic [2*W-1:0] d);
        int j;
        if (locked == 0) begin
            exp_d = '0;
            exp_s = 1'b0;
            if (s) begin
                locked = 1;
                hist.delete();
                hist.push_back(d);
                cnt = 1;
            end
        end else begin
            j = cnt;
            hist.push_back(d);
            if (j >= N) begin
                exp_d = hist[(j / N - 1) * N + brev(j % N)];
                exp_s = ((j % N) == 0);
            end else begin
                exp_d = '0;
                exp_s = 1'b0;
            end
            cnt++;
        end
    endtask

    task automatic check(input string tag);
        checks++;
        assert (dout === exp_d) else begin
            errors++;
            $error("FAIL %s o_data got %h expected %h", tag, dout, exp_d);
        end
        checks++;
        assert (osync === exp_s) else begin
            errors++;
            $error("FAIL %s o_sync got %b expected %b", tag, osync, exp_s);
        end
    endtask

    task automatic step(input logic c, input logic s, input logic [2*W-1:0] d, input string tag);
        ce   = c;
        sync = s;
        din  = d;
        @(posedge clk);
        if (c) model(s, d);
        #1;
        check(tag);
        ce   = 1'b0;
        sync = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_async");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    int guard;
    logic [2*W-1:0] rv;

    initial begin
        // Reset state
        #2;
        check("reset_state");
        #10;
        rst_n = 1'b1;

        // Pre-sync discard, then basic reorder over three frames
        step(1'b1, 1'b0, 16'd99, "presync");
        step(1'b1, 1'b0, 16'd98, "presync");
        step(1'b1, 1'b0, 16'd97, "presync");
        for (int v = 0; v < 24; v++)
            step(1'b1, (v == 0 || v == 8), 16'(v), "basic");

        // Gapped strobe, one in three clocks; outputs must hold while idle
        do_reset();
        for (int v = 0; v < 24; v++) begin
            step(1'b1, (v == 0 || v == 8), 16'(v), "gapped");
            step(1'b0, 1'b0, 16'hDEAD, "gapped_hold");
            step(1'b0, 1'b1, 16'hBEEF, "gapped_hold");
        end

        // Spurious sync at k=3 while running; random data
        for (int i = 0; i < 3 * N; i++) begin
            rv = 16'($urandom);
            step(1'b1, ((cnt % N) == 3), rv, "spurious");
        end

        // Async reset while o_sync is high, then FILL latency restarts
        guard = 0;
        while (exp_s !== 1'b1 && guard < 4 * N) begin
            step(1'b1, 1'b0, 16'($urandom), "pre_areset");
            guard++;
        end
        checks++;
        assert (exp_s === 1'b1 && osync === 1'b1) else begin
            errors++;
            $error("FAIL areset_setup o_sync got %b expected %b", osync, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("areset_midframe");
        @(posedge clk);
        #1;
        check("areset_held");
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 2 * N; i++)
            step(1'b1, (i == 0), 16'($urandom), "after_reset");

        // Full-scale alternating patterns
        for (int i = 0; i < 2 * N; i++)
            step(1'b1, 1'b0, (i % 2 == 0) ? 16'h7F80 : 16'h807F, "fullscale");
        for (int i = 0; i < N; i++)
            step(1'b1, 1'b0, (i % 3 == 0) ? 16'h807F : 16'h7F80, "fullscale2");

        // Random strobe gaps, random syncs and data
        do_reset();
        for (int i = 0; i < 120; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 16'($urandom), "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
